addsub_accum: RTL
=================

ADDSUB_ACCUM -- requirements
Module: addsub_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/accumulator width, two's complement signed.
REQ-002 SHALL have parameter BATCH, default 4: operations per batch, legal range 1..255.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream operand valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operand this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  signed operand.
REQ-008 SHALL have port in_sub  input  1  0 = acc + in_data, 1 = acc - in_data.
REQ-009 SHALL have port out_valid  output  1  batch result available.
REQ-010 SHALL have port out_ready  input  1  downstream consumes result.
REQ-011 SHALL have port out_sum  output  WIDTH  signed batch result.
REQ-012 SHALL have port out_of  output  1  sticky signed overflow seen during batch.
REQ-013 SHALL have port out_neg  output  1  out_sum < 0 (MSB of out_sum).
REQ-014 SHALL have port busy  output  1  at least one operand accepted in current batch, or result pending.

Function
REQ-015 SHALL implement FSM states ACC and DONE; ACC: in_ready=1, out_valid=0; DONE: in_ready=0, out_valid=1.
REQ-016 SHALL accept an operand only when in_valid && in_ready in the same cycle; no buffering of unaccepted beats.
REQ-017 SHALL, on accept, update acc to acc ± in_data (per in_sub) and increment an internal count; one operation per cycle max.
REQ-018 SHALL detect signed overflow per op: add -- operands same sign, result sign differs; sub -- acc and in_data signs differ, result sign differs from acc.
REQ-019 SHALL set the sticky overflow flag on any overflowing op; flag clears only at batch restart or reset.
REQ-020 SHALL transition ACC -> DONE on the accept that makes count equal BATCH; out_valid asserts the following cycle (latency 1 from final accept).
REQ-021 SHALL hold out_sum, out_of, out_neg stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-022 SHALL, in DONE with out_ready=1, return to ACC next cycle with acc=0, count=0, overflow flag=0.
REQ-023 SHALL ignore in_valid in DONE, including the cycle in which out_ready=1; the first new operand is accepted no earlier than the following cycle.
REQ-024 SHALL drive out_sum from acc and out_of from the sticky flag in all states; values are qualified only by out_valid.
REQ-025 SHALL, for BATCH=1, enter DONE after every single accepted operand.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, force state=ACC, acc=0, count=0, sticky flag=0, regardless of state or handshake inputs.
REQ-027 SHALL present after reset: in_ready=1, out_valid=0, out_sum=0, out_of=0, out_neg=0, busy=0.
REQ-028 SHALL discard a partial batch or pending result when reset asserts mid-operation; no result for it is ever presented.

Configuration
REQ-029 SHALL, with macro ADDSUB_ACCUM_SAT_EN defined, clamp an overflowing result to +max (0x7FFF at WIDTH 16) on positive overflow and -max-1 (0x8000) on negative overflow, still setting the sticky flag.
REQ-030 SHALL, without ADDSUB_ACCUM_SAT_EN, wrap results modulo 2^WIDTH (plain two's complement), still setting the sticky flag.

Verification (WIDTH=16, BATCH=4)
REQ-031 SHALL cover: add 16, add 4, add 256, add -32 back-to-back -> out_valid one cycle after 4th accept, out_sum=244, out_of=0, out_neg=0.
REQ-032 SHALL cover: add 32767, add 1, add 0, add 0 -> out_of=1; out_sum=-32768 without SAT_EN, 32767 with SAT_EN.
REQ-033 SHALL cover: sub -32768 from acc 0, then add 0 x3 -> out_of=1; out_sum=-32768 without SAT_EN, 32767 with SAT_EN.
REQ-034 SHALL cover: result pending, out_ready=0 for 5 cycles with in_valid=1 -> out_valid, out_sum held, in_ready=0, no operand consumed.
REQ-035 SHALL cover: reset for one cycle after 2 accepts (8192, -2048), then add 16, 4, -1024, 1 -> out_sum=-1003, out_of=0.
REQ-036 SHALL cover: in_valid=1 continuously, out_ready=1 in DONE -> next batch's first operand accepted the cycle after out_valid drops, not in the handshake cycle.

Source files
------------

// File: rtl/addsub_accum.sv
// Batched signed add/subtract accumulator; optional saturation via `ADDSUB_ACCUM_SAT_EN.
// Latency: out_valid rises 1 cycle after the BATCH-th accepted operand.
// Backpressure: in_ready is low while a result waits; the result holds until out_ready.
module addsub_accum #(
  parameter int WIDTH = 16,
  parameter int BATCH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_of,
  output logic             out_neg,
  output logic             busy
);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam logic [7:0]       BATCH_CNT = 8'(BATCH);
  localparam logic [WIDTH-1:0] SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [7:0]       count;
  logic             of_flag;

  logic             accept;
  logic [WIDTH-1:0] raw_sum;
  logic             op_ovf;
  logic [WIDTH-1:0] next_acc;
  logic             last_op;

  // Per-operation arithmetic, signed overflow detection and optional clamping
  always_comb begin
    accept  = in_valid && (state == ACC);
    raw_sum = in_sub ? (acc - in_data) : (acc + in_data);
    if (in_sub) begin
      // Subtract overflows when signs differ and the result leaves acc's sign
      op_ovf = (acc[WIDTH-1] != in_data[WIDTH-1]) && (raw_sum[WIDTH-1] != acc[WIDTH-1]);
    end else begin
      op_ovf = (acc[WIDTH-1] == in_data[WIDTH-1]) && (raw_sum[WIDTH-1] != acc[WIDTH-1]);
    end
`ifdef ADDSUB_ACCUM_SAT_EN
    // On overflow the true result always lies on acc's side of zero
    if (op_ovf) begin
      next_acc = acc[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end else begin
      next_acc = raw_sum;
    end
`else
    next_acc = raw_sum;
`endif
    last_op = ((count + 8'd1) == BATCH_CNT);
  end

  // Batch FSM: accumulate in ACC, hold the result in DONE until consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ACC;
      acc     <= '0;
      count   <= '0;
      of_flag <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc     <= next_acc;
            count   <= count + 8'd1;
            of_flag <= of_flag | op_ovf;
            if (last_op) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          // in_valid is ignored here, even in the handshake cycle
          if (out_ready) begin
            state   <= ACC;
            acc     <= '0;
            count   <= '0;
            of_flag <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  // Outputs decode directly from registered state
  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == DONE);
    out_sum   = acc;
    out_of    = of_flag;
    out_neg   = acc[WIDTH-1];
    busy      = (state == DONE) || (count != 8'd0);
  end

  // Unused constant suppressed when saturation is compiled out
  logic unused_sat;
  always_comb begin
    unused_sat = ^{SAT_MAX, SAT_MIN};
  end

endmodule
